// File: rtl/lsu_data_arb_pkg.sv
// Shared types for the LSU data-port arbiter.
// Request/ack bundles, FSM states and idle encodings.
package lsu_data_arb_pkg;

  localparam int LSU_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } lsu_ack_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } lsu_arb_state_e;

  // Idle downstream request: everything zero but size=1.
  localparam lsu_req_t LSU_REQ_IDLE = '{
    req:   1'b0,
    we:    1'b0,
    size:  2'd1,
    be:    4'd0,
    addr:  32'd0,
    wdata: 32'd0
  };

  localparam lsu_ack_t LSU_ACK_IDLE = '{
    ack:   1'b0,
    error: 1'b0,
    rdata: 32'd0
  };

  localparam lsu_ack_t LSU_ACK_TMO = '{
    ack:   1'b1,
    error: 1'b1,
    rdata: 32'd0
  };

endpackage

// File: rtl/lsu_data_arb_rr_pick.sv
// Combinational round-robin picker.
// Scans from ptr upward, wrapping modulo NUM_REQ.
module lsu_data_arb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // First active requester at or after ptr wins.
  always_comb begin
    logic [IDX_W-1:0] j;
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(ptr) + i >= NUM_REQ) begin
        j = IDX_W'(int'(ptr) + i - NUM_REQ);
      end else begin
        j = IDX_W'(int'(ptr) + i);
      end
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/lsu_data_arb.sv
// Round-robin arbiter sharing one LSU data port.
// Grant is held until ack; a watchdog ends hung transfers.
module lsu_data_arb
  import lsu_data_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 256,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  lsu_req_t [NUM_REQ-1:0]   lsu_req_i,
  output lsu_ack_t [NUM_REQ-1:0]   lsu_ack_o,
  output lsu_req_t                 lsu_req_o,
  input  lsu_ack_t                 lsu_ack_i,
  output logic                     busy_o,
  output logic [IDX_W-1:0]         grant_idx_o,
  output logic                     timeout_o
);

  localparam int WD_W =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  lsu_arb_state_e      state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    lock_idx;
  logic [WD_W-1:0]     wdog_cnt;

  logic [NUM_REQ-1:0]  req_vec;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic                lock_req;
  logic                wd_hit;

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] i
  );
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Gather the request bits for the picker.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vec[i] = lsu_req_i[i].req;
    end
  end

  lsu_data_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_vec),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign lock_req = lsu_req_i[lock_idx].req;
  assign wd_hit   = (TIMEOUT_CYC != 0) &&
                    (wdog_cnt == WD_W'(TIMEOUT_CYC));

  // Output muxing; everything is forced idle during reset.
  always_comb begin
    lsu_req_o   = LSU_REQ_IDLE;
    lsu_ack_o   = '{default: LSU_ACK_IDLE};
    busy_o      = 1'b0;
    grant_idx_o = '0;
    timeout_o   = 1'b0;
    if (rst_ni) begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            grant_idx_o = pick_idx;
            lsu_req_o   = lsu_req_i[pick_idx];
            if (lsu_ack_i.ack) begin
              lsu_ack_o[pick_idx] = lsu_ack_i;
            end
          end
        end
        ARB_LOCK: begin
          busy_o      = 1'b1;
          grant_idx_o = lock_idx;
          if (!lock_req) begin
            lsu_req_o = LSU_REQ_IDLE;
          end else if (lsu_ack_i.ack) begin
            lsu_req_o           = lsu_req_i[lock_idx];
            lsu_ack_o[lock_idx] = lsu_ack_i;
          end else if (wd_hit) begin
            lsu_ack_o[lock_idx] = LSU_ACK_TMO;
            timeout_o           = 1'b1;
          end else begin
            lsu_req_o = lsu_req_i[lock_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, round-robin pointer and watchdog counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
      wdog_cnt <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            if (lsu_ack_i.ack) begin
              rr_ptr <= nxt(pick_idx);
            end else begin
              lock_idx <= pick_idx;
              wdog_cnt <= WD_W'(1);
              state    <= ARB_LOCK;
            end
          end
        end
        ARB_LOCK: begin
          if (!lock_req) begin
            wdog_cnt <= '0;
            state    <= ARB_IDLE;
          end else if (lsu_ack_i.ack || wd_hit) begin
            rr_ptr   <= nxt(lock_idx);
            wdog_cnt <= '0;
            state    <= ARB_IDLE;
          end else if (wdog_cnt != '1) begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data_arb.sv
// Directed bench for lsu_data_arb.
// Two requesters, hand-driven slave, watchdog of 4 cycles.
module tb_lsu_data_arb;
  import lsu_data_arb_pkg::*;

  localparam int NR = 2;

  logic               clk;
  logic               rst_n;
  lsu_req_t [NR-1:0]  req_i;
  lsu_ack_t [NR-1:0]  ack_o;
  lsu_req_t           req_o;
  lsu_ack_t           ack_i;
  logic               busy;
  logic [0:0]         gidx;
  logic               tmo;

  int vecs = 0;
  int errs = 0;

  lsu_data_arb #(
    .NUM_REQ     (NR),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .lsu_req_i   (req_i),
    .lsu_ack_o   (ack_o),
    .lsu_req_o   (req_o),
    .lsu_ack_i   (ack_i),
    .busy_o      (busy),
    .grant_idx_o (gidx),
    .timeout_o   (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic lsu_req_t mk(input logic [31:0] a);
    lsu_req_t r;
    r       = LSU_REQ_IDLE;
    r.req   = 1'b1;
    r.size  = 2'd2;
    r.be    = 4'hf;
    r.addr  = a;
    return r;
  endfunction

  function automatic lsu_ack_t mka(
    input logic a, input logic e, input logic [31:0] d
  );
    lsu_ack_t k;
    k.ack   = a;
    k.error = e;
    k.rdata = d;
    return k;
  endfunction

  // Advance to the next drive point, just after a falling edge.
  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req_i[0] = mk(32'h10000);
    req_i[1] = mk(32'h90004);
    ack_i    = mka(1'b1, 1'b0, 32'h11);

    // Reset forces all outputs idle
    nxt(); settle();
    chk("rst_req",  64'(req_o.req), 64'd0);
    chk("rst_size", 64'(req_o.size), 64'd1);
    chk("rst_addr", 64'(req_o.addr), 64'd0);
    chk("rst_ack0", 64'(ack_o[0]), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gidx", 64'(gidx), 64'd0);

    // Single-cycle slave, alternation 0,1,0
    nxt(); rst_n = 1'b1; settle();
    chk("alt0_gidx", 64'(gidx), 64'd0);
    chk("alt0_addr", 64'(req_o.addr), 64'h10000);
    chk("alt0_ack0", 64'(ack_o[0].ack), 64'd1);
    chk("alt0_ack1", 64'(ack_o[1].ack), 64'd0);
    nxt(); settle();
    chk("alt1_rr",   64'(dut.rr_ptr), 64'd1);
    chk("alt1_gidx", 64'(gidx), 64'd1);
    chk("alt1_addr", 64'(req_o.addr), 64'h90004);
    chk("alt1_ack1", 64'(ack_o[1].ack), 64'd1);
    chk("alt1_ack0", 64'(ack_o[0].ack), 64'd0);
    nxt(); settle();
    chk("alt2_rr",   64'(dut.rr_ptr), 64'd0);
    chk("alt2_gidx", 64'(gidx), 64'd0);
    nxt(); req_i = '{default: LSU_REQ_IDLE};
    ack_i = mka(1'b0, 1'b0, 32'h0); settle();
    chk("alt_rr",    64'(dut.rr_ptr), 64'd1);
    chk("idle_req",  64'(req_o.req), 64'd0);
    chk("idle_size", 64'(req_o.size), 64'd1);

    // Slow slave: req1 locks, req0 waits
    nxt(); req_i[1] = mk(32'h90004); settle();
    chk("slow0_gidx", 64'(gidx), 64'd1);
    chk("slow0_addr", 64'(req_o.addr), 64'h90004);
    chk("slow0_busy", 64'(busy), 64'd0);
    nxt(); req_i[0] = mk(32'h10000); settle();
    chk("slow1_busy", 64'(busy), 64'd1);
    chk("slow1_ack0", 64'(ack_o[0].ack), 64'd0);
    chk("slow1_gidx", 64'(gidx), 64'd1);
    chk("slow1_addr", 64'(req_o.addr), 64'h90004);
    nxt(); settle();
    chk("slow2_busy", 64'(busy), 64'd1);
    chk("slow2_ack1", 64'(ack_o[1].ack), 64'd0);
    nxt(); ack_i = mka(1'b1, 1'b0, 32'hDEADBEEF); settle();
    chk("slow3_ack1",  64'(ack_o[1].ack), 64'd1);
    chk("slow3_rdata", 64'(ack_o[1].rdata), 64'hDEADBEEF);
    chk("slow3_ack0",  64'(ack_o[0].ack), 64'd0);
    nxt(); req_i[1] = LSU_REQ_IDLE;
    ack_i = mka(1'b1, 1'b0, 32'h0); settle();
    chk("slow4_rr",   64'(dut.rr_ptr), 64'd0);
    chk("slow4_busy", 64'(busy), 64'd0);
    chk("slow4_gidx", 64'(gidx), 64'd0);
    chk("slow4_addr", 64'(req_o.addr), 64'h10000);
    chk("slow4_ack0", 64'(ack_o[0].ack), 64'd1);
    nxt(); req_i = '{default: LSU_REQ_IDLE};
    ack_i = mka(1'b0, 1'b0, 32'h0); settle();

    // Watchdog: req0 never acked, fires 4 cycles after grant
    nxt(); req_i[0] = mk(32'h20000); settle();
    chk("wd0_gidx", 64'(gidx), 64'd0);
    nxt(); req_i[1] = mk(32'h90008); settle();
    chk("wd1_tmo",  64'(tmo), 64'd0);
    chk("wd1_gidx", 64'(gidx), 64'd0);
    nxt(); settle();
    nxt(); settle();
    chk("wd3_tmo",  64'(tmo), 64'd0);
    chk("wd3_req",  64'(req_o.req), 64'd1);
    nxt(); settle();
    chk("wd4_tmo",  64'(tmo), 64'd1);
    chk("wd4_ack0", 64'(ack_o[0]), 64'(mka(1'b1, 1'b1, 32'h0)));
    chk("wd4_req",  64'(req_o.req), 64'd0);
    chk("wd4_ack1", 64'(ack_o[1].ack), 64'd0);
    nxt(); req_i[0] = LSU_REQ_IDLE;
    ack_i = mka(1'b1, 1'b0, 32'h5); settle();
    chk("wd5_busy", 64'(busy), 64'd0);
    chk("wd5_tmo",  64'(tmo), 64'd0);
    chk("wd5_gidx", 64'(gidx), 64'd1);
    chk("wd5_addr", 64'(req_o.addr), 64'h90008);
    nxt(); req_i = '{default: LSU_REQ_IDLE};
    ack_i = mka(1'b0, 1'b0, 32'h0); settle();

    // Downstream error is passed through
    nxt(); req_i[0] = mk(32'h50000);
    ack_i = mka(1'b1, 1'b1, 32'h0); settle();
    chk("err_gidx", 64'(gidx), 64'd0);
    chk("err_ack",  64'(ack_o[0].ack), 64'd1);
    chk("err_err",  64'(ack_o[0].error), 64'd1);
    chk("err_tmo",  64'(tmo), 64'd0);
    nxt(); req_i = '{default: LSU_REQ_IDLE};
    ack_i = mka(1'b0, 1'b0, 32'h0); settle();
    chk("err_rr", 64'(dut.rr_ptr), 64'd1);

    // Reset mid-LOCK abandons the transfer
    nxt(); req_i[1] = mk(32'h90010); settle();
    chk("rl0_gidx", 64'(gidx), 64'd1);
    nxt(); settle();
    chk("rl1_busy", 64'(busy), 64'd1);
    nxt(); rst_n = 1'b0;
    ack_i = mka(1'b1, 1'b0, 32'h77); settle();
    chk("rl2_ack1", 64'(ack_o[1]), 64'd0);
    chk("rl2_busy", 64'(busy), 64'd0);
    nxt(); rst_n = 1'b1; req_i[0] = mk(32'h10000);
    ack_i = mka(1'b1, 1'b0, 32'h0); settle();
    chk("rl3_busy", 64'(busy), 64'd0);
    chk("rl3_rr",   64'(dut.rr_ptr), 64'd0);
    chk("rl3_gidx", 64'(gidx), 64'd0);
    chk("rl3_ack0", 64'(ack_o[0].ack), 64'd1);

    // Locked requester drops req without ack
    nxt(); req_i[0] = LSU_REQ_IDLE;
    ack_i = mka(1'b0, 1'b0, 32'h0); settle();
    chk("dr0_gidx", 64'(gidx), 64'd1);
    chk("dr0_rr",   64'(dut.rr_ptr), 64'd1);
    nxt(); req_i[1] = LSU_REQ_IDLE; settle();
    chk("dr1_busy", 64'(busy), 64'd1);
    chk("dr1_req",  64'(req_o.req), 64'd0);
    chk("dr1_ack1", 64'(ack_o[1].ack), 64'd0);
    nxt(); settle();
    chk("dr2_busy", 64'(busy), 64'd0);
    chk("dr2_rr",   64'(dut.rr_ptr), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
